// File: rtl/nexys_starship_monster_ctrl.sv
// Monster lane controller for the starship game: spawn, shoot, expiry and score.
// Optional macro NEXYS_STARSHIP_SPEEDUP_EN shortens monster lifetime as the score grows.
module nexys_starship_monster_ctrl #(
    parameter int unsigned TIMEOUT    = 8,
    parameter int unsigned MAX_ACTIVE = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] spawn_req,
    input  logic       shoot,
    input  logic [1:0] shoot_dir,
    output logic [3:0] monster,
    output logic [7:0] score,
    output logic [1:0] game_state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } state_e;

    localparam logic [2:0] MaxActive = 3'(MAX_ACTIVE);

    state_e     state_q, state_d;
    logic [3:0] monster_q, monster_d;
    logic [7:0] score_q, score_d;
    logic [3:0] timer_q [4];
    logic [3:0] timer_d [4];
    logic [3:0] eff_timeout;
    logic [3:0] kill_mask;
    logic [3:0] expire;
    logic [2:0] active;

`ifdef NEXYS_STARSHIP_SPEEDUP_EN
    localparam logic [4:0] TimeoutW = 5'(TIMEOUT);
    logic [4:0] sub_w;

    // Every 16 kills shave one tick off the lifetime, never below 2.
    assign sub_w       = {1'b0, score_q[7:4]};
    assign eff_timeout = ((sub_w + 5'd2) > TimeoutW) ? 4'd2 : 4'(TimeoutW - sub_w);
`else
    assign eff_timeout = 4'(TIMEOUT);
`endif

    always_comb begin
        state_d   = state_q;
        monster_d = monster_q;
        score_d   = score_q;
        timer_d   = timer_q;
        kill_mask = 4'b0000;
        expire    = 4'b0000;
        active    = 3'd0;

        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d   = StPlay;
                    monster_d = 4'b0000;
                    score_d   = 8'd0;
                    for (int i = 0; i < 4; i++) begin
                        timer_d[i] = 4'd0;
                    end
                end
            end
            StPlay: begin
                // A shot is resolved before expiry, so it wins over an expiring lane.
                if (shoot && monster_q[shoot_dir]) begin
                    kill_mask[shoot_dir] = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end
                monster_d = monster_q & ~kill_mask;

                if (tick) begin
                    for (int i = 0; i < 4; i++) begin
                        if (monster_d[i]) begin
                            if (timer_q[i] == 4'd1) begin
                                expire[i] = 1'b1;
                            end else begin
                                timer_d[i] = timer_q[i] - 4'd1;
                            end
                        end
                    end

                    for (int i = 0; i < 4; i++) begin
                        active = active + {2'b00, monster_d[i]};
                    end

                    // Fixed priority by lane index; requests beyond the cap are dropped.
                    for (int i = 0; i < 4; i++) begin
                        if (spawn_req[i] && !monster_d[i] && !kill_mask[i]
                            && (active < MaxActive)) begin
                            monster_d[i] = 1'b1;
                            timer_d[i]   = eff_timeout;
                            active       = active + 3'd1;
                        end
                    end

                    if (|expire) begin
                        state_d = StOver;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            monster_q <= 4'b0000;
            score_q   <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                timer_q[i] <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            monster_q <= monster_d;
            score_q   <= score_d;
            for (int i = 0; i < 4; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign monster    = monster_q;
    assign score      = score_q;
    assign game_state = state_q;
    assign game_over  = (state_q == StOver);

endmodule
